// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
//   ADDR_W / INSTR_W : address and instruction widths
//   NOP_INSTR        : value presented on if_instr after reset
//   fetch_state_e    : fetch controller state encoding
package fetch_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DROP,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/sat_cnt16.sv
// sat_cnt16: 16-bit up-counter that sticks at 16'hFFFF.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears count)
//   en    : count enable
//   clr   : synchronous clear, takes priority over en
//   cnt   : current count
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] cnt
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller between the PC updater, the
// instruction memory and the IF/ID register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   pc_cur         : current PC
//   pc_en          : PC updater advances this cycle (combinational)
//   imem_req/addr  : instruction-memory request and address (combinational)
//   imem_ready     : memory returns imem_rdata this cycle
//   stall          : hazard unit holds IF/ID
//   redirect       : taken branch, flush fetch
//   hlt_dec        : HLT decoded, stop the core
//   if_instr/valid : registered instruction to ID
//   halted         : registered halt flag
//   stall_cycles   : saturating count of memory wait cycles
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_cur,
    output logic               pc_en,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic               hlt_dec,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid,
    output logic               halted,
    output logic [15:0]        stall_cycles
);

    fetch_state_e       r_state;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_halted;
    logic [INSTR_W-1:0] r_buf;

    logic               w_req;
    logic               w_pc_en;
    logic               w_wait;

    // Request is a pure function of state so the address stays stable for
    // the whole access regardless of same-cycle control inputs.
    always_comb begin
        w_req   = (r_state == ST_FETCH);
        w_pc_en = 1'b0;
        if (!hlt_dec) begin
            case (r_state)
                ST_FETCH: w_pc_en = redirect | imem_ready;
                ST_HOLD,
                ST_DROP:  w_pc_en = redirect;
                default:  w_pc_en = 1'b0;
            endcase
        end
    end

    assign w_wait    = w_req & ~imem_ready;
    assign pc_en     = w_pc_en;
    assign imem_req  = w_req;
    assign imem_addr = w_req ? pc_cur : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_instr  <= NOP_INSTR;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_buf    <= '0;
        end else if (r_state == ST_HALT) begin
            r_state <= ST_HALT;
        end else if (hlt_dec) begin
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (redirect) begin
                        // An access still in flight must be drained in DROP.
                        r_valid <= 1'b0;
                        r_state <= imem_ready ? ST_FETCH : ST_DROP;
                    end else if (stall) begin
                        if (imem_ready) begin
                            r_buf   <= imem_rdata;
                            r_state <= ST_HOLD;
                        end
                    end else if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        r_valid <= 1'b0;
                        r_state <= ST_FETCH;
                    end else if (!stall) begin
                        r_instr <= r_buf;
                        r_valid <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    r_valid <= 1'b0;
                    if (imem_ready) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sat_cnt16 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_wait),
        .clr   (1'b0),
        .cnt   (stall_cycles)
    );

    assign if_instr = r_instr;
    assign if_valid = r_valid;
    assign halted   = r_halted;

endmodule
